// File: rtl/zeroheti_pkg.sv
// -----------------------------------------------------------------------------
// zeroheti_pkg
// Shared types and constants for the APB request manager.
//   apb_mgr_state_e      : 2-bit FSM state encoding (IDLE, SETUP, ACCESS, RESP)
//   ApbMgrDefaultTimeout : default ACCESS-phase cycle limit for the watchdog
// -----------------------------------------------------------------------------
package zeroheti_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mgr_state_e;

    localparam int unsigned ApbMgrDefaultTimeout = 255;

endpackage

// File: rtl/apb_mgr_wdt.sv
// -----------------------------------------------------------------------------
// apb_mgr_wdt
// ACCESS-phase watchdog for apb_req_mgr. Only instantiated when
// APB_MGR_TIMEOUT_EN is defined.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous reset, active-high
//   clr_i      : clear the count (asserted the cycle before ACCESS is entered)
//   en_i       : count this cycle (ACCESS with pready low)
//   expired_o  : this counted cycle brings the count to TimeoutCycles
// -----------------------------------------------------------------------------
module apb_mgr_wdt #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] r_cnt;

    // Expiry is decided on the cycle whose increment would reach the limit,
    // so the manager leaves ACCESS on that same edge.
    assign expired_o = en_i && (r_cnt == LastCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !expired_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_req_mgr.sv
// -----------------------------------------------------------------------------
// apb_req_mgr
// APB3 manager: converts a valid/ready request/response channel into single
// APB transfers, one at a time, with all APB outputs registered.
//
// Handshake: a request transfers on an edge where req_valid_i && req_ready_o;
// a response transfers on an edge where rsp_valid_o && rsp_ready_i. Once
// rsp_valid_o is high it and the response payload stay stable until taken.
//
// Optional: define APB_MGR_TIMEOUT_EN to abort ACCESS after TimeoutCycles
// cycles without pready_i (response then carries rsp_err_o = 1, rdata 0).
//
// Ports:
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   req_valid_i/req_ready_o          : request handshake
//   req_addr_i/req_write_i/req_wdata_i : request payload
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_rdata_o/rsp_err_o            : response payload
//   paddr_o/psel_o/penable_o/pwrite_o/pwdata_o : APB manager outputs
//   prdata_i/pready_i/pslverr_i      : APB subordinate inputs
// -----------------------------------------------------------------------------
module apb_req_mgr
    import zeroheti_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = ApbMgrDefaultTimeout
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pready_i,
    input  logic                 pslverr_i
);

    apb_mgr_state_e       r_state;
    logic                 r_live;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [AddrWidth-1:0] r_paddr;
    logic [DataWidth-1:0] r_pwdata;
    logic                 r_rsp_valid;
    logic [DataWidth-1:0] r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 w_timeout;

    // r_live is low for the cycle following a reset edge so that every
    // output, including req_ready_o, reads 0 while reset is being applied.
    assign req_ready_o = (r_state == IDLE) && r_live;

`ifdef APB_MGR_TIMEOUT_EN
    apb_mgr_wdt #(
        .TimeoutCycles (TimeoutCycles)
    ) u_wdt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (r_state == SETUP),
        .en_i      ((r_state == ACCESS) && !pready_i),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_live      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        r_paddr  <= req_addr_i;
                        r_pwrite <= req_write_i;
                        r_pwdata <= req_wdata_i;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // prdata_i/pslverr_i are only meaningful with pready_i.
                    if (pready_i) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                        r_rsp_err   <= pslverr_i;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: doc/apb_req_mgr.md
Name: apb_req_mgr

Overview:
- APB3 manager (initiator) that turns a valid/ready request/response channel into single APB transfers toward the peripheral subsystem.
- Lets non-core agents (test DMA, debug bridge, boot sequencer) drive the same APB subordinates as the core: mtimer, uart, i2c.
- Handles one transfer at a time and registers all APB outputs.

Parameters:
- AddrWidth, 32, width of request address and paddr_o
- DataWidth, 32, width of wdata/rdata
- TimeoutCycles, 255, ACCESS-phase cycle limit, used only with APB_MGR_TIMEOUT_EN; must be ≥1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  AddrWidth  transfer address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DataWidth  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DataWidth  read data; 0 for writes
- rsp_err_o  out  1  pslverr or timeout
- paddr_o  out  AddrWidth  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DataWidth  APB write data
- prdata_i  in  DataWidth  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error

Behaviour:
- Reset: when rst_i is sampled high, every output is 0 at the next edge (req_ready_o, rsp_*, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o), and the FSM goes to IDLE.
- Reset mid-transfer drops psel_o immediately. The subordinate must tolerate this.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o = 1, combinational from state only; it does not depend on req_valid_i.
  - On req_valid_i, latch addr/write/wdata into paddr_o/pwrite_o/pwdata_o and go to SETUP.
- SETUP: psel_o = 1, penable_o = 0. Unconditionally go to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - On pready_i: capture rsp_rdata_o = prdata_i if a read, else 0; capture rsp_err_o = pslverr_i; go to RESP.
  - prdata_i and pslverr_i are ignored while pready_i = 0.
- Leaving ACCESS: psel_o and penable_o clear on the same edge.
- paddr_o, pwrite_o and pwdata_o:
  - Stable from SETUP through ACCESS.
  - Hold their last value afterwards.
  - Change only on acceptance.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o are stable.
  - On rsp_ready_i, go to IDLE.
  - No new request is accepted in RESP (req_ready_o = 0).
- Latency:
  - Acceptance at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2.
  - With pready_i = 1 in ACCESS, rsp_valid_o is high in cycle N+3.
  - Each wait state adds one cycle.
  - Minimum request-to-request spacing is 4 cycles when rsp_ready_i is held at 1.
- Back-pressure: rsp_ready_i = 0 stalls indefinitely in RESP, with no APB activity.
- pslverr_i = 1 with pready_i = 1 gives rsp_err_o = 1. Read data is still passed through.

Optional Feature:
- Macro: APB_MGR_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - When the count reaches TimeoutCycles, go to RESP with rsp_err_o = 1 and rsp_rdata_o = 0. psel_o and penable_o drop on that edge.
  - pready_i = 1 in the same cycle that the count reaches TimeoutCycles counts as success; the timeout does not fire.
  - Counter width is $clog2(TimeoutCycles+1).
- Without the macro: no counter exists, and ACCESS waits for pready_i forever.

Decomposition:
- zeroheti_pkg gains:
  - apb_mgr_state_e (IDLE, SETUP, ACCESS, RESP; 2-bit)
  - constant ApbMgrDefaultTimeout = 255
- One sub-module, apb_mgr_wdt:
  - Handles clear, count enable and expired.
  - Instantiated only under APB_MGR_TIMEOUT_EN.
- The FSM and registers stay in apb_req_mgr.

Test Plan:
- Write, zero wait:
  - Stimulus: addr 0x0000_3000, wdata 0xDEAD_BEEF, pready_i = 1.
  - Required: psel_o high in cycles N+1 and N+2; penable_o high only in N+2; pwrite_o = 1; rsp_valid_o in N+3 with rsp_err_o = 0 and rsp_rdata_o = 0.
- Read, 3 wait states:
  - Stimulus: prdata_i = 0x1234_5678 presented only with pready_i.
  - Required: rsp_rdata_o = 0x1234_5678 in N+6; paddr_o stable throughout ACCESS.
- Subordinate error:
  - Stimulus: pslverr_i = 1 with pready_i = 1.
  - Required: rsp_err_o = 1; the next request is accepted only after the rsp handshake.
- Response back-pressure:
  - Stimulus: rsp_ready_i held 0 for 10 cycles while req_valid_i stays high.
  - Required: req_ready_o = 0, psel_o = 0 and rsp values stable throughout; the second transfer starts the cycle after the handshake.
- Reset mid-ACCESS:
  - Stimulus: rst_i asserted during a wait state.
  - Required: all outputs are 0 the next cycle; after release, a clean transfer completes.
- Timeout (APB_MGR_TIMEOUT_EN, TimeoutCycles = 4):
  - Stimulus: pready_i tied 0.
  - Required: RESP with rsp_err_o = 1 after 4 ACCESS cycles.
  - Repeat with pready_i rising in the 4th cycle: rsp_err_o = 0.
